serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 1.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: start  input  1  request pulse/level; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while a bit-serial addition is in progress (state RUN).
REQ-009 Port: done  output  1  one-cycle completion strobe (state DONE).
REQ-010 Port: sum  output  WIDTH  registered result.
REQ-011 Port: cout  output  1  registered carry-out of the MSB.

Function
REQ-012 The block SHALL instantiate exactly one full_adder (ports a, b, c, sum, carry) and SHALL compute every result bit through it, with no other adder logic.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, encoded in a registered state variable.
REQ-014 IDLE: start=1 at a rising edge latches a, b and cin into internal shift/carry registers, clears the bit counter to 0 and moves to RUN; start=0 keeps IDLE.
REQ-015 RUN, each edge: full_adder inputs = LSB of A-shift, LSB of B-shift and carry register; the sum bit shifts into the MSB of the result-shift register; the carry register takes the full_adder carry; A/B shift right by 1; the counter increments.
REQ-016 RUN SHALL last exactly WIDTH edges; on the edge that processes bit WIDTH-1, the FSM moves to DONE and sum/cout load the completed result-shift register and final carry.
REQ-017 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE unconditionally.
REQ-018 Latency: when start is accepted at edge k, done SHALL be high between edges k+WIDTH and k+WIDTH+1; busy SHALL be high between edges k and k+WIDTH.
REQ-019 Arithmetic: {cout, sum} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-020 sum and cout SHALL change only at completion (REQ-016) or reset, and SHALL hold the last result through IDLE and RUN of a following operation.
REQ-021 start SHALL be ignored in RUN and DONE; a, b and cin changes after acceptance SHALL NOT affect the operation in flight.
REQ-022 With start held high continuously, operations SHALL run back-to-back with one IDLE cycle between DONE and the next acceptance, giving a period of WIDTH+2 cycles.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within an operation; for WIDTH=1, RUN lasts one edge.
REQ-024 busy and done SHALL be decoded from state only, and SHALL never be high together.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE and clear the counter, the shift registers, the carry register, sum, cout, busy and done to 0, without waiting for a clock edge.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Verification (WIDTH=8)
REQ-027 a=100, b=27, cin=0, start pulse at edge k -> busy high for 8 cycles; done high for one cycle at k+8; sum=127, cout=0.
REQ-028 a=255, b=1, cin=0 -> sum=0, cout=1; a=255, b=255, cin=1 -> sum=255, cout=1.
REQ-029 Accept a=10, b=20, then change a/b to 200/200 and pulse start during RUN -> result sum=30, cout=0; exactly one done pulse.
REQ-030 start held high over three operations (1+1, 2+2, 3+3) -> done pulses at k+8, k+18 and k+28; sums 2, 4, 6.
REQ-031 rst asserted asynchronously after 4 bits of 100+27 -> all outputs read 0 before the next edge; no done pulse; a following 5+6 gives sum=11.
REQ-032 Exhaustive or random check against a+b+cin over at least 1000 operand sets, including WIDTH=1 (all 8 input combinations match the full_adder truth table).

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder is reused over WIDTH clock
// edges to form {cout, sum} = a + b + cin, LSB first.

// Single-bit full adder; the only arithmetic element in the datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; a 1-bit result is just the sum bit itself
  generate
    if (WIDTH == 1) begin : g_res_w1
      always_comb res_next = fa_sum;
    end else begin : g_res_wn
      always_comb res_next = {fa_sum, res[WIDTH-1:1]};
    end
  endgenerate

  // Status strobes are pure state decodes
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // FSM, operand shifters, carry, counter and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= fa_carry;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= fa_carry;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       st8, ci8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       st1, ci1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [8:0]  last8;
  logic [1:0]  last1;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One WIDTH=8 operation; tamper changes operands and pulses start mid-run
  task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc, input bit tamper);
    logic [8:0] exp;
    exp = 9'(xa) + 9'(xb) + 9'(xc);
    @(negedge clk);
    a8 = xa; b8 = xb; ci8 = xc; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("busy8_run", busy8, 1);
      chk("done8_run", done8, 0);
      chk("hold8_run", {cout8, sum8}, last8);
      if (tamper && i == 2) begin a8 = 8'd200; b8 = 8'd200; ci8 = 1'b1; st8 = 1'b1; end
      if (tamper && i == 3) st8 = 1'b0;
      @(negedge clk);
    end
    chk("done8", done8, 1);
    chk("busy8_done", busy8, 0);
    chk("res8", {cout8, sum8}, exp);
    last8 = exp;
    @(negedge clk);
    chk("done8_after", done8, 0);
    chk("busy8_after", busy8, 0);
    if (tamper) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("tamper_idle", {busy8, done8}, 0);
      end
      chk("tamper_res", {cout8, sum8}, exp);
    end
  endtask

  // One WIDTH=1 operation: RUN is a single edge
  task automatic op1(input logic xa, input logic xb, input logic xc);
    logic [1:0] exp;
    exp = 2'(xa) + 2'(xb) + 2'(xc);
    @(negedge clk);
    a1 = xa; b1 = xb; ci1 = xc; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    chk("busy1_run", {busy1, done1}, 2'b10);
    chk("hold1_run", {cout1, sum1}, last1);
    @(negedge clk);
    chk("done1", {busy1, done1}, 2'b01);
    chk("res1", {cout1, sum1}, exp);
    last1 = exp;
    @(negedge clk);
    chk("idle1", {busy1, done1}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; ci8 = 0;
    st1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    last8 = '0; last1 = '0;
    #2;
    chk("rst_out8", {busy8, done8, cout8, sum8}, 0);
    chk("rst_out1", {busy1, done1, cout1, sum1}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    op8(8'd100, 8'd27, 1'b0, 0);
    op8(8'd255, 8'd1, 1'b0, 0);
    op8(8'd255, 8'd255, 1'b1, 0);
    op8(8'd10, 8'd20, 1'b0, 1);

    // start held high: three back-to-back ops, period WIDTH+2
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; ci8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= 28; t++) begin
      chk("b2b_busy", busy8, ((t % 10) < 8) ? 1 : 0);
      chk("b2b_done", done8, ((t % 10) == 8) ? 1 : 0);
      if (t == 8)  chk("b2b_sum1", {cout8, sum8}, 2);
      if (t == 18) chk("b2b_sum2", {cout8, sum8}, 4);
      if (t == 28) chk("b2b_sum3", {cout8, sum8}, 6);
      if (t == 1)  begin a8 = 8'd2; b8 = 8'd2; end
      if (t == 11) begin a8 = 8'd3; b8 = 8'd3; end
      if (t == 28) st8 = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end", {busy8, done8}, 0);
    last8 = 9'd6;

    // Asynchronous reset after 4 bits of 100+27
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd27; ci8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out", {busy8, done8, cout8, sum8}, 0);
    @(negedge clk);
    rst = 1'b0;
    last8 = '0; last1 = '0;
    for (int i = 0; i < 10; i++) begin
      chk("arst_nodone", {busy8, done8}, 0);
      @(negedge clk);
    end
    op8(8'd5, 8'd6, 1'b0, 0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    // Random operands against a+b+cin
    for (int i = 0; i < 1000; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 40; i++)
      op1(1'($urandom), 1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
